// File: rtl/mmac_pkg.sv
// mmac_pkg: shared widths and drain state type for the matrix MAC.
//   DATA_WIDTH : element width of operands and drained results
//   M_SIZE     : matrix dimension (M_SIZE x M_SIZE)
//   ACC_WIDTH  : accumulator width, 2*DATA_WIDTH + log2(M_SIZE)
//   IDX_WIDTH  : width of a flat element index
package mmac_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int M_SIZE     = 4;
    localparam int NUM_ELEM   = M_SIZE * M_SIZE;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(M_SIZE);
    localparam int IDX_WIDTH  = $clog2(NUM_ELEM);
    typedef enum logic {IDLE, STREAM} drain_state_t;
endpackage

// File: rtl/mmac_sat.sv
// mmac_sat: arithmetic right shift of one accumulator, then narrow to DATA_WIDTH.
//   acc_i  : signed accumulator
//   data_o : scaled, narrowed element
//   ovf_o  : element was clipped
// With MMAC_DRAIN_SAT_EN defined the narrowing saturates; otherwise it wraps.
module mmac_sat
    import mmac_pkg::*;
#(
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic        [DATA_WIDTH-1:0] data_o,
    output logic                         ovf_o
);
`ifdef MMAC_DRAIN_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_WIDTH-1:0] s;
    logic hi, lo;
    always_comb begin
        s      = acc_i >>> OUT_SHIFT;
        hi     = s > SAT_MAX;
        lo     = s < SAT_MIN;
        ovf_o  = hi | lo;
        data_o = hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                 lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : s[DATA_WIDTH-1:0];
    end
`else
    assign data_o = DATA_WIDTH'(acc_i >>> OUT_SHIFT);
    assign ovf_o  = 1'b0;
`endif
endmodule

// File: rtl/mmac_result_drain.sv
// mmac_result_drain: capture one accumulator matrix, stream it out one element per beat.
//   clk, rst           : clock, asynchronous active-high reset
//   res_valid/ready    : matrix handshake, res_data holds all M_SIZE*M_SIZE accumulators
//   out_valid/ready    : element handshake
//   out_data, out_ovf  : scaled/narrowed element and its clip flag
//   out_row, out_col   : element coordinates; out_last marks the final element
// Optional saturation: define MMAC_DRAIN_SAT_EN.
module mmac_result_drain
    import mmac_pkg::*;
#(
    parameter int OUT_SHIFT = 0,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 res_valid,
    output logic                                 res_ready,
    input  logic [NUM_ELEM*ACC_WIDTH-1:0]        res_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [IDX_WIDTH/2-1:0]               out_row,
    output logic [IDX_WIDTH/2-1:0]               out_col,
    output logic                                 out_last,
    output logic                                 out_ovf
);
    localparam int H = IDX_WIDTH / 2;
    drain_state_t state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [NUM_ELEM-1:0][ACC_WIDTH-1:0] buf_q, buf_d;
    logic last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end
    // The last beat reopens res_ready in the same cycle so a waiting matrix
    // is captured without a bubble.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        last      = idx_q == IDX_WIDTH'(NUM_ELEM - 1);
        out_valid = state_q == STREAM;
        res_ready = out_valid ? last && out_ready : 1'b1;
        if (res_valid && res_ready) begin
            buf_d   = res_data;
            idx_d   = '0;
            state_d = STREAM;
        end else if (out_valid && out_ready) begin
            idx_d   = idx_q + 1'b1;
            state_d = last ? IDLE : STREAM;
        end
    end
    assign out_last = out_valid && last;
    assign out_row  = COL_MAJOR ? idx_q[H-1:0] : idx_q[IDX_WIDTH-1 -: H];
    assign out_col  = COL_MAJOR ? idx_q[IDX_WIDTH-1 -: H] : idx_q[H-1:0];
    mmac_sat #(.OUT_SHIFT(OUT_SHIFT)) u_sat (
        .acc_i  (buf_q[{out_row, out_col}]),
        .data_o (out_data),
        .ovf_o  (out_ovf)
    );
endmodule

// File: tb/tb_mmac_result_drain.sv
// tb_mmac_result_drain: three drain variants on shared stimulus, checked against a beat-queue model.
module tb_mmac_result_drain;
    localparam int AW = 34;
    logic clk = 1'b0, rst = 1'b1, res_valid = 1'b0, out_ready = 1'b0;
    logic [16*AW-1:0] res_data;
    logic [AW-1:0] m [16];
    logic rr [3], ov [3], olast [3], oovf [3];
    logic [15:0] od [3];
    logic [1:0] orow [3], ocol [3];
    logic [21:0] q [3][$];
    int sh [3] = '{0, 0, 2};
    bit cm [3] = '{1'b0, 1'b1, 1'b0};
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    always_comb begin
        res_data = '0;
        for (int i = 0; i < 16; i++) res_data[i*AW +: AW] = m[i];
    end
    mmac_result_drain #(.OUT_SHIFT(0), .COL_MAJOR(1'b0)) u0 (.clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(rr[0]), .res_data(res_data), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]),
        .out_last(olast[0]), .out_ovf(oovf[0]));
    mmac_result_drain #(.OUT_SHIFT(0), .COL_MAJOR(1'b1)) u1 (.clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(rr[1]), .res_data(res_data), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]),
        .out_last(olast[1]), .out_ovf(oovf[1]));
    mmac_result_drain #(.OUT_SHIFT(2), .COL_MAJOR(1'b0)) u2 (.clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(rr[2]), .res_data(res_data), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_row(orow[2]), .out_col(ocol[2]),
        .out_last(olast[2]), .out_ovf(oovf[2]));
    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Expected beats of one captured matrix in streaming order.
    task automatic push(int i);
        int r, c;
        logic signed [AW-1:0] s;
        logic [15:0] d;
        bit o;
        for (int k = 0; k < 16; k++) begin
            r = cm[i] ? k % 4 : k / 4;
            c = cm[i] ? k / 4 : k % 4;
            s = $signed(m[r*4+c]) >>> sh[i];
            d = s[15:0];
            o = 1'b0;
`ifdef MMAC_DRAIN_SAT_EN
            if (s > 32767) begin d = 16'h7fff; o = 1'b1; end
            else if (s < -32768) begin d = 16'h8000; o = 1'b1; end
`endif
            q[i].push_back({d, 2'(r), 2'(c), k == 15, o});
        end
    endtask
    task automatic step();
        bit exp_rr;
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) q[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_rr = q[i].size() == 0 || (q[i].size() == 1 && out_ready);
                chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(q[i].size() != 0));
                chk($sformatf("res_ready[%0d]", i), 64'(rr[i]), 64'(exp_rr));
                if (ov[i] && q[i].size() != 0) begin
                    chk($sformatf("beat[%0d]", i), 64'({od[i], orow[i], ocol[i], olast[i], oovf[i]}), 64'(q[i][0]));
                    if (out_ready) void'(q[i].pop_front());
                end
                if (res_valid && exp_rr) push(i);
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic chk_reset(string tag);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s[%0d]", tag, i),
                64'({ov[i], rr[i], od[i], orow[i], ocol[i], olast[i], oovf[i]}),
                64'({1'b0, 1'b1, 16'h0, 2'b0, 2'b0, 1'b0, 1'b0}));
    endtask
    task automatic rand_matrix();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) begin
            v = {$urandom, $urandom};
            m[i] = $urandom_range(0, 2) == 0 ? AW'($signed(v[15:0])) : v[AW-1:0];
        end
    endtask
    task automatic capture();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 16; i++) m[i] = AW'(i);
        #12;
        chk_reset("reset_state");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        capture();
        repeat (18) step();
        capture();
        repeat (5) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (13) step();
        rand_matrix();
        capture();
        repeat (15) step();
        rand_matrix();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        chk("no_bubble", 64'(ov[0]), 64'd1);
        repeat (17) step();
        rand_matrix();
        m[0] = 34'h0_0004_0000;
        m[1] = -34'sh0_0004_0000;
        capture();
`ifdef MMAC_DRAIN_SAT_EN
        chk("sat_pos", 64'({od[2], oovf[2]}), 64'({16'h7fff, 1'b1}));
        step();
        chk("sat_neg", 64'({od[2], oovf[2]}), 64'({16'h8000, 1'b1}));
`else
        chk("sat_pos", 64'({od[2], oovf[2]}), 64'({16'h0000, 1'b0}));
        step();
        chk("sat_neg", 64'({od[2], oovf[2]}), 64'({16'h0000, 1'b0}));
`endif
        repeat (16) step();
        rand_matrix();
        capture();
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk_reset("midstream_reset");
        step();
        rst = 1'b0;
        rand_matrix();
        capture();
        repeat (17) step();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) rand_matrix();
            res_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        res_valid = 1'b0;
        out_ready = 1'b1;
        repeat (18) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
